// File: rtl/random_pick.sv
// Draws a uniformly distributed hole index from a free-running random byte stream
// by rejection sampling, never repeating the previously delivered index.
module random_pick #(
  parameter int NUM_HOLES = 9,
  parameter int IDX_W     = 4,
  parameter int MAX_TRIES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       rand_byte,
  input  logic             req,
  output logic             busy,
  output logic             pick_valid,
  output logic [IDX_W-1:0] pick,
  output logic             fallback
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [IDX_W:0]   HOLES_W  = (IDX_W + 1)'(NUM_HOLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_HOLES - 1);
  localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
  localparam logic [TRY_W-1:0] TRY_SAT  = TRY_W'(MAX_TRIES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_r, state_next_s;
  logic [TRY_W-1:0] tries_r, tries_next_s;
  logic             have_last_r, have_last_next_s;
  logic [IDX_W-1:0] pick_r, pick_next_s;
  logic             fallback_r, fallback_next_s;
  logic             busy_r, pick_valid_r;

  logic [IDX_W-1:0] cand_s;
  logic             accept_s;
  logic [IDX_W-1:0] fallback_idx_s;
  logic             unused_s;

  assign cand_s   = rand_byte[IDX_W-1:0];
  assign unused_s = ^rand_byte[7:IDX_W];

  // Candidate is legal when in range and different from the last delivered index
  assign accept_s = ({1'b0, cand_s} < HOLES_W) && !(have_last_r && (cand_s == pick_r));

  // Fallback steps past the previous pick (wrapping) so it can never repeat it
  always_comb begin
    fallback_idx_s = ZERO_IDX;
    if (!have_last_r) begin
      fallback_idx_s = ZERO_IDX;
    end else if (pick_r == LAST_IDX) begin
      fallback_idx_s = ZERO_IDX;
    end else begin
      fallback_idx_s = pick_r + IDX_W'(1);
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_next_s     = state_r;
    tries_next_s     = tries_r;
    have_last_next_s = have_last_r;
    pick_next_s      = pick_r;
    fallback_next_s  = fallback_r;
    case (state_r)
      IDLE: begin
        if (req) begin
          state_next_s = SAMPLE;
          tries_next_s = {TRY_W{1'b0}};
        end else begin
          state_next_s = IDLE;
        end
      end
      SAMPLE: begin
        if (accept_s) begin
          pick_next_s     = cand_s;
          fallback_next_s = 1'b0;
          state_next_s    = DONE;
        end else if (tries_r == LAST_TRY) begin
          pick_next_s     = fallback_idx_s;
          fallback_next_s = 1'b1;
          state_next_s    = DONE;
        end else if (tries_r == TRY_SAT) begin
          tries_next_s = tries_r;
        end else begin
          tries_next_s = tries_r + TRY_W'(1);
        end
      end
      DONE: begin
        have_last_next_s = 1'b1;
        state_next_s     = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath and registered outputs; status flags follow the upcoming state
  always_ff @(posedge clock) begin
    if (reset) begin
      tries_r      <= {TRY_W{1'b0}};
      have_last_r  <= 1'b0;
      pick_r       <= ZERO_IDX;
      fallback_r   <= 1'b0;
      busy_r       <= 1'b0;
      pick_valid_r <= 1'b0;
    end else begin
      tries_r      <= tries_next_s;
      have_last_r  <= have_last_next_s;
      pick_r       <= pick_next_s;
      fallback_r   <= fallback_next_s;
      busy_r       <= (state_next_s != IDLE);
      pick_valid_r <= (state_next_s == DONE);
    end
  end

  assign busy       = busy_r;
  assign pick_valid = pick_valid_r;
  assign pick       = pick_r;
  assign fallback   = fallback_r;

endmodule

// File: tb/tb_random_pick.sv
// Directed and randomized self-checking bench for random_pick (9 holes, 16 tries).
module tb_random_pick;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rand_byte = 8'h00;
  logic       req = 1'b0;
  logic       busy;
  logic       pick_valid;
  logic [3:0] pick;
  logic       fallback;

  int checks = 0;
  int errors = 0;

  random_pick #(.NUM_HOLES(9), .IDX_W(4), .MAX_TRIES(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .rand_byte  (rand_byte),
    .req        (req),
    .busy       (busy),
    .pick_valid (pick_valid),
    .pick       (pick),
    .fallback   (fallback)
  );

  always #5 clock = ~clock;

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; rand_byte = 8'h00;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (pick_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pick_valid); end
    checks++; if (pick !== 4'd0) begin errors++; $display("FAIL reset_pick: got %0d expected 0", pick); end
    checks++; if (fallback !== 1'b0) begin errors++; $display("FAIL reset_fallback: got %b expected 0", fallback); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_first_pick();
    req = 1'b1; rand_byte = 8'h35;
    @(negedge clock);
    req = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_busy_t1: got %b expected 1", busy); end
    checks++; if (pick_valid !== 1'b0) begin errors++; $display("FAIL first_valid_t1: got %b expected 0", pick_valid); end
    @(negedge clock);
    checks++; if (pick_valid !== 1'b1) begin errors++; $display("FAIL first_valid_t2: got %b expected 1", pick_valid); end
    checks++; if (pick !== 4'd5) begin errors++; $display("FAIL first_pick: got %0d expected 5", pick); end
    checks++; if (fallback !== 1'b0) begin errors++; $display("FAIL first_fallback: got %b expected 0", fallback); end
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL first_busy_t3: got %b expected 0", busy); end
    checks++; if (pick_valid !== 1'b0) begin errors++; $display("FAIL first_valid_t3: got %b expected 0", pick_valid); end
    checks++; if (pick !== 4'd5) begin errors++; $display("FAIL first_pick_hold: got %0d expected 5", pick); end
  endtask

  task automatic test_reject_sequence();
    logic [7:0] seq [3];
    seq[0] = 8'h0C; seq[1] = 8'h05; seq[2] = 8'h17;
    req = 1'b1;
    @(negedge clock);
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_byte = seq[i];
      @(negedge clock);
      if (i < 2) begin
        checks++; if (pick_valid !== 1'b0) begin errors++; $display("FAIL rej_early_valid[%0d]: got %b expected 0", i, pick_valid); end
      end
    end
    checks++; if (pick_valid !== 1'b1) begin errors++; $display("FAIL rej_valid_t4: got %b expected 1", pick_valid); end
    checks++; if (pick !== 4'd7) begin errors++; $display("FAIL rej_pick: got %0d expected 7", pick); end
    checks++; if (fallback !== 1'b0) begin errors++; $display("FAIL rej_fallback: got %b expected 0", fallback); end
    @(negedge clock);
  endtask

  task automatic test_fallback_wrap();
    req = 1'b1; rand_byte = 8'h08;
    @(negedge clock);
    req = 1'b0;
    @(negedge clock);
    checks++; if (pick_valid !== 1'b1 || pick !== 4'd8) begin errors++; $display("FAIL wrap_setup: got valid=%b pick=%0d expected valid=1 pick=8", pick_valid, pick); end
    @(negedge clock);
    req = 1'b1; rand_byte = 8'h0F;
    @(negedge clock);
    req = 1'b0;
    for (int i = 1; i < 16; i++) begin
      @(negedge clock);
      checks++; if (pick_valid !== 1'b0) begin errors++; $display("FAIL wrap_early_valid[%0d]: got %b expected 0", i, pick_valid); end
    end
    @(negedge clock);
    checks++; if (pick_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid_t17: got %b expected 1", pick_valid); end
    checks++; if (pick !== 4'd0) begin errors++; $display("FAIL wrap_pick: got %0d expected 0", pick); end
    checks++; if (fallback !== 1'b1) begin errors++; $display("FAIL wrap_fallback: got %b expected 1", fallback); end
    @(negedge clock);
  endtask

  task automatic test_first_after_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    req = 1'b1; rand_byte = 8'hFF;
    @(negedge clock);
    req = 1'b0;
    repeat (16) @(negedge clock);
    checks++; if (pick_valid !== 1'b1 || pick !== 4'd0 || fallback !== 1'b1) begin
      errors++; $display("FAIL nolast_fallback: got valid=%b pick=%0d fb=%b expected valid=1 pick=0 fb=1", pick_valid, pick, fallback);
    end
    @(negedge clock);
    req = 1'b1;
    @(negedge clock);
    req = 1'b0; rand_byte = 8'h00;
    @(negedge clock);
    rand_byte = 8'h03;
    checks++; if (pick_valid !== 1'b0) begin errors++; $display("FAIL excl_zero_valid: got %b expected 0", pick_valid); end
    @(negedge clock);
    checks++; if (pick_valid !== 1'b1 || pick !== 4'd3 || fallback !== 1'b0) begin
      errors++; $display("FAIL excl_zero_pick: got valid=%b pick=%0d fb=%b expected valid=1 pick=3 fb=0", pick_valid, pick, fallback);
    end
    @(negedge clock);
  endtask

  task automatic test_req_while_busy();
    int pulses;
    pulses = 0;
    req = 1'b1;
    @(negedge clock);
    req = 1'b0; rand_byte = 8'h0F;
    @(negedge clock);
    req = 1'b1; rand_byte = 8'h02;
    @(negedge clock);
    checks++; if (pick_valid !== 1'b1 || pick !== 4'd2) begin
      errors++; $display("FAIL busy_req_pick: got valid=%b pick=%0d expected valid=1 pick=2", pick_valid, pick);
    end
    @(negedge clock);
    req = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_req_idle: got %b expected 0", busy); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (pick_valid === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL busy_req_extra: got %0d active cycles expected 0", pulses); end
  endtask

  task automatic test_reset_mid();
    req = 1'b1;
    @(negedge clock);
    req = 1'b0; rand_byte = 8'h0F;
    @(negedge clock);
    reset = 1'b1; rand_byte = 8'h02;
    @(negedge clock);
    reset = 1'b0;
    checks++; if (pick_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_status: got valid=%b busy=%b expected 0 0", pick_valid, busy);
    end
    checks++; if (pick !== 4'd0 || fallback !== 1'b0) begin
      errors++; $display("FAIL mid_reset_pick: got pick=%0d fb=%b expected 0 0", pick, fallback);
    end
    @(negedge clock);
    checks++; if (pick_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_late: got %b expected 0", pick_valid); end
    req = 1'b1; rand_byte = 8'h00;
    @(negedge clock);
    req = 1'b0;
    @(negedge clock);
    checks++; if (pick_valid !== 1'b1 || pick !== 4'd0 || fallback !== 1'b0) begin
      errors++; $display("FAIL mid_reset_noexcl: got valid=%b pick=%0d fb=%b expected valid=1 pick=0 fb=0", pick_valid, pick, fallback);
    end
    @(negedge clock);
  endtask

  task automatic test_random();
    int hist [9];
    logic [3:0] last;
    logic [3:0] exp_pick;
    logic [3:0] cand;
    logic       exp_fb;
    logic [31:0] r;
    int tries;
    bit done;
    for (int i = 0; i < 9; i++) hist[i] = 0;
    last = 4'd0;
    for (int n = 0; n < 10000; n++) begin
      req = 1'b1; r = $urandom; rand_byte = r[7:0];
      @(negedge clock);
      req = 1'b0;
      tries = 0; done = 1'b0; exp_pick = 4'd0; exp_fb = 1'b0;
      while (!done) begin
        r = $urandom; rand_byte = r[7:0]; cand = r[3:0];
        @(negedge clock);
        if (cand < 4'd9 && cand != last) begin
          exp_pick = cand; exp_fb = 1'b0; done = 1'b1;
        end else if (tries == 15) begin
          exp_pick = (last == 4'd8) ? 4'd0 : last + 4'd1; exp_fb = 1'b1; done = 1'b1;
        end else begin
          tries++;
        end
      end
      checks++; if (pick_valid !== 1'b1 || pick !== exp_pick || fallback !== exp_fb) begin
        errors++; $display("FAIL rand_pick[%0d]: got valid=%b pick=%0d fb=%b expected valid=1 pick=%0d fb=%b", n, pick_valid, pick, fallback, exp_pick, exp_fb);
      end
      checks++; if (pick === last) begin errors++; $display("FAIL rand_repeat[%0d]: got %0d expected not %0d", n, pick, last); end
      checks++; if (!(pick < 4'd9)) begin errors++; $display("FAIL rand_range[%0d]: got %0d expected < 9", n, pick); end
      if (pick < 4'd9) hist[pick]++;
      last = exp_pick;
      @(negedge clock);
    end
    for (int i = 0; i < 9; i++) begin
      checks++; if (hist[i] < 1000 || hist[i] > 1222) begin
        errors++; $display("FAIL rand_hist[%0d]: got %0d expected 1000..1222", i, hist[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_pick();
    test_reject_sequence();
    test_fallback_wrap();
    test_first_after_reset();
    test_req_while_busy();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
